// File: rtl/alpha_blend_ctrl_pkg.sv
// Shared definitions for the alpha-blend controller: FSM encoding and sizing constants.
package alpha_blend_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_LINE_GAP = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;

  localparam int unsigned DIM_WIDTH_DEF = 12;
  localparam int unsigned DP_LATENCY    = 6;

endpackage

// File: rtl/alpha_win_cmp.sv
// Combinational overlay-window test for the current pixel position.
module alpha_win_cmp
  import alpha_blend_ctrl_pkg::*;
#(
  parameter int g_DIM_WIDTH = DIM_WIDTH_DEF
) (
  input  logic [g_DIM_WIDTH-1:0] x_i,
  input  logic [g_DIM_WIDTH-1:0] y_i,
  input  logic [g_DIM_WIDTH-1:0] win_x_i,
  input  logic [g_DIM_WIDTH-1:0] win_y_i,
  input  logic [g_DIM_WIDTH-1:0] win_w_i,
  input  logic [g_DIM_WIDTH-1:0] win_h_i,
  input  logic                   alpha_en_i,
  output logic                   in_win_o
);

  // One extra bit so a window reaching past the frame edge never wraps.
  logic [g_DIM_WIDTH:0] x_end;
  logic [g_DIM_WIDTH:0] y_end;

  assign x_end = {1'b0, win_x_i} + {1'b0, win_w_i};
  assign y_end = {1'b0, win_y_i} + {1'b0, win_h_i};

  assign in_win_o = alpha_en_i
                  && (x_i >= win_x_i) && ({1'b0, x_i} < x_end)
                  && (y_i >= win_y_i) && ({1'b0, y_i} < y_end);

endmodule

// File: rtl/alpha_blend_ctrl.sv
// Frame sequencer for the alpha-blend datapath: paces FIFO reads per pixel,
// inserts line gaps, and tracks in-flight pixels until the frame drains.
module alpha_blend_ctrl
  import alpha_blend_ctrl_pkg::*;
#(
  parameter int g_DIM_WIDTH  = DIM_WIDTH_DEF,
  parameter int g_LINE_GAP   = 4,
  parameter int g_PEND_WIDTH = 4
) (
  input  logic                   SYS_CLK_I,
  input  logic                   RESET_n_I,
  input  logic                   FRAME_START_I,
  input  logic [g_DIM_WIDTH-1:0] HRES_I,
  input  logic [g_DIM_WIDTH-1:0] VRES_I,
  input  logic [g_DIM_WIDTH-1:0] WIN_X_I,
  input  logic [g_DIM_WIDTH-1:0] WIN_Y_I,
  input  logic [g_DIM_WIDTH-1:0] WIN_W_I,
  input  logic [g_DIM_WIDTH-1:0] WIN_H_I,
  input  logic                   ALPHA_EN_I,
  input  logic                   V1_EMPTY_I,
  input  logic                   V2_EMPTY_I,
  output logic                   V1_RE_O,
  output logic                   V2_RE_O,
  output logic                   VALID_O,
  output logic                   START_BLEND_O,
  input  logic                   VOUT_VALID_I,
  output logic                   BUSY_O,
  output logic                   FRAME_DONE_O
);

  localparam int GAP_W = (g_LINE_GAP > 1) ? $clog2(g_LINE_GAP) : 1;
  localparam logic [g_DIM_WIDTH-1:0] DIM_ONE  = g_DIM_WIDTH'(1);
  localparam logic [GAP_W-1:0]       GAP_LAST = GAP_W'(g_LINE_GAP - 1);

  state_t                  state_q;
  logic [g_DIM_WIDTH-1:0]  hres_q, vres_q;
  logic [g_DIM_WIDTH-1:0]  win_x_q, win_y_q, win_w_q, win_h_q;
  logic                    alpha_en_q;
  logic [g_DIM_WIDTH-1:0]  x_q, y_q;
  logic [GAP_W-1:0]        gap_q;
  logic [g_PEND_WIDTH-1:0] pend_q, pend_d;
  logic                    valid_q, start_q, done_q;

  logic in_win, adv, v1_re, v2_re, last_px, last_ln, gap_done;

  alpha_win_cmp #(
    .g_DIM_WIDTH(g_DIM_WIDTH)
  ) u_win_cmp (
    .x_i       (x_q),
    .y_i       (y_q),
    .win_x_i   (win_x_q),
    .win_y_i   (win_y_q),
    .win_w_i   (win_w_q),
    .win_h_i   (win_h_q),
    .alpha_en_i(alpha_en_q),
    .in_win_o  (in_win)
  );

  // Handshake: a read enable is a same-cycle request against a non-empty FIFO,
  // only in ACTIVE; the FIFO word appears one cycle later, qualified by VALID_O
  // (background) and START_BLEND_O (overlay), which are the read enables delayed.
  assign adv      = (state_q == ST_ACTIVE) && !V2_EMPTY_I && (!in_win || !V1_EMPTY_I);
  assign v2_re    = adv;
  assign v1_re    = adv && in_win;
  assign last_px  = (x_q == hres_q - DIM_ONE);
  assign last_ln  = (y_q == vres_q - DIM_ONE);
  assign gap_done = (gap_q == GAP_LAST);

  // Concurrent issue and retire leave the count unchanged.
  always_comb begin
    pend_d = pend_q;
    if (valid_q && !VOUT_VALID_I && (pend_q != '1)) begin
      pend_d = pend_q + g_PEND_WIDTH'(1);
    end else if (!valid_q && VOUT_VALID_I && (pend_q != '0)) begin
      pend_d = pend_q - g_PEND_WIDTH'(1);
    end
  end

  always_ff @(posedge SYS_CLK_I or negedge RESET_n_I) begin
    if (!RESET_n_I) begin
      state_q    <= ST_IDLE;
      hres_q     <= '0;
      vres_q     <= '0;
      win_x_q    <= '0;
      win_y_q    <= '0;
      win_w_q    <= '0;
      win_h_q    <= '0;
      alpha_en_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      gap_q      <= '0;
      pend_q     <= '0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      valid_q <= v2_re;
      start_q <= v1_re;
      done_q  <= 1'b0;
      pend_q  <= pend_d;
      case (state_q)
        ST_IDLE: begin
          if (FRAME_START_I) begin
            hres_q     <= HRES_I;
            vres_q     <= VRES_I;
            win_x_q    <= WIN_X_I;
            win_y_q    <= WIN_Y_I;
            win_w_q    <= WIN_W_I;
            win_h_q    <= WIN_H_I;
            alpha_en_q <= ALPHA_EN_I;
            x_q        <= '0;
            y_q        <= '0;
            gap_q      <= '0;
            // An empty frame skips straight to DRAIN so it still completes.
            state_q    <= ((HRES_I == '0) || (VRES_I == '0)) ? ST_DRAIN : ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (adv) begin
            if (last_px) begin
              x_q     <= '0;
              gap_q   <= '0;
              state_q <= ST_LINE_GAP;
            end else begin
              x_q <= x_q + DIM_ONE;
            end
          end
        end
        ST_LINE_GAP: begin
          if (gap_done) begin
            gap_q <= '0;
            if (last_ln) begin
              state_q <= ST_DRAIN;
            end else begin
              y_q     <= y_q + DIM_ONE;
              state_q <= ST_ACTIVE;
            end
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        ST_DRAIN: begin
          if ((pend_q == '0) && !valid_q) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign V1_RE_O       = v1_re;
  assign V2_RE_O       = v2_re;
  assign VALID_O       = valid_q;
  assign START_BLEND_O = start_q;
  assign BUSY_O        = (state_q != ST_IDLE);
  assign FRAME_DONE_O  = done_q;

endmodule
